// File: rtl/act_pkg.sv
// Shared widths and helpers for the interpolating activation unit.
// Saturation works on int so any DATA_W up to 31 bits can reuse it.
package act_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FRAC_W = DATA_W - ADDR_W;

  function automatic int sat(input int v, input int w);
    int hi;
    int lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/act_lut_interp_if.sv
// Sample-in / result-out valid-ready bundle of the activation unit.
// master drives samples and consumes results; slave is the unit side.
interface act_lut_interp_if #(
  parameter int DATA_W = act_pkg::DATA_W
) (
  input logic clk
);

  logic                     in_valid;
  logic                     in_ready;
  logic        [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    input  clk,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output in_valid,
    output in_data,
    output out_ready
  );

  modport slave (
    input  clk,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/act_lerp_mac.sv
// Combinational lerp step: base + floor(diff*frac / 2^FRAC_W), saturated.
// frac is unsigned, so it is zero-extended before the signed multiply.
module act_lerp_mac
  import act_pkg::*;
#(
  parameter int DATA_W = act_pkg::DATA_W,
  parameter int FRAC_W = act_pkg::FRAC_W
) (
  input  logic signed [DATA_W-1:0] base,
  input  logic signed [DATA_W:0]   diff,
  input  logic        [FRAC_W-1:0] frac,
  output logic signed [DATA_W-1:0] y
);

  localparam int PROD_W = DATA_W + FRAC_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] step;
  int                       sum;

  always_comb begin
    prod = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    step = prod >>> FRAC_W;
    sum  = int'(base) + int'(step);
    y    = DATA_W'(sat(sum, DATA_W));
  end

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage LUT activation with linear interpolation between entries.
// One global advance moves all stages; a stalled output freezes the pipe.
module act_lut_interp
  import act_pkg::*;
#(
  parameter int DATA_W = act_pkg::DATA_W,
  parameter int ADDR_W = act_pkg::ADDR_W,
  parameter int FRAC_W = DATA_W - ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic        [DATA_W-1:0] in_data,
  output logic        [ADDR_W-1:0] lut_address,
  input  logic signed [DATA_W-1:0] lut_base,
  input  logic signed [DATA_W-1:0] lut_next,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data
);

  logic                     adv;
  logic                     v1;
  logic                     v2;
  logic        [ADDR_W-1:0] idx1;
  logic        [FRAC_W-1:0] frac1;
  logic        [FRAC_W-1:0] frac2;
  logic signed [DATA_W-1:0] base2;
  logic signed [DATA_W:0]   diff2;
  logic signed [DATA_W:0]   diff;
  logic signed [DATA_W-1:0] y;

  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign lut_address = idx1;
  assign diff        = (DATA_W+1)'(lut_next) - (DATA_W+1)'(lut_base);

  act_lerp_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .base (base2),
    .diff (diff2),
    .frac (frac2),
    .y    (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      idx1      <= '0;
      frac1     <= '0;
      frac2     <= '0;
      base2     <= '0;
      diff2     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      idx1      <= in_data[DATA_W-1 -: ADDR_W];
      frac1     <= in_data[FRAC_W-1:0];
      v2        <= v1;
      base2     <= lut_base;
      diff2     <= diff;
      frac2     <= frac1;
      out_valid <= v2;
      // Bubbles leave the last result on the output untouched.
      if (v2)
        out_data <= y;
    end
  end

endmodule

// File: tb/tb_act_lut_interp.sv
// Bench for act_lut_interp: fixed vectors, random stall stream, reset flush.
// Expected values come from an arithmetic model of the interpolation rule.
module tb_act_lut_interp;

  typedef struct {
    logic [7:0] x;
    int         y;
  } vec_t;

  typedef struct {
    int y;
    int acc;
  } exp_t;

  logic clk;
  logic rst;
  logic [3:0] lut_address;
  logic [3:0] nidx;
  logic signed [7:0] lut_base;
  logic signed [7:0] lut_next;
  logic signed [7:0] lut [16];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_rdy = 0;
  bit lat_chk  = 0;
  bit stalled  = 0;
  int held     = 0;
  exp_t sb[$];
  vec_t tbl[7];

  act_lut_interp_if #(.DATA_W(8)) bus (.clk(clk));

  act_lut_interp dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .in_data     (bus.in_data),
    .lut_address (lut_address),
    .lut_base    (lut_base),
    .lut_next    (lut_next),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .out_data    (bus.out_data)
  );

  assign nidx     = (lut_address == 4'd7) ? 4'd7 : lut_address + 4'd1;
  assign lut_base = lut[lut_address];
  assign lut_next = lut[nidx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic int ref_y(logic [7:0] x);
    int i, f, b, n, p, q, y;
    i = int'(x[7:4]);
    f = int'(x[3:0]);
    b = lut[i];
    n = (i == 7) ? lut[7] : lut[(i + 1) % 16];
    p = (n - b) * f;
    q = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    y = b + q;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy)
      bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(logic [7:0] x, int y);
    bit   ok;
    exp_t e;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok    = 1;
        e.y   = y;
        e.acc = cyc;
        sb.push_back(e);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok)
      check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++)
      tick();
    if (sb.size() != 0)
      check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 0;
    end else begin
      check("in_ready", int'(bus.in_ready),
            int'(!(bus.out_valid && !bus.out_ready)));
      if (stalled) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'(bus.out_data), held);
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = int'(bus.out_data);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", int'(bus.out_data), 999);
        end else begin
          e = sb.pop_front();
          check("y", int'(bus.out_data), e.y);
          if (lat_chk)
            check("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    logic [7:0] x;
    lut = '{0, 12, 15, 15, 15, 15, 15, 15,
            -15, -15, -15, -15, -15, -15, -15, -12};
    tbl[0] = '{8'h08, 6};
    tbl[1] = '{8'h18, 13};
    tbl[2] = '{8'h70, 15};
    tbl[3] = '{8'h7F, 15};
    tbl[4] = '{8'h88, -15};
    tbl[5] = '{8'hF8, -6};
    tbl[6] = '{8'hF0, -12};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_lut_address", int'(lut_address), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    tick();

    lat_chk = 1;
    for (int i = 0; i < 7; i++)
      send(tbl[i].x, tbl[i].y);
    drain();
    lat_chk = 0;

    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        tick();
      x = 8'($urandom_range(0, 255));
      send(x, ref_y(x));
    end
    rand_rdy = 0;
    bus.out_ready = 1'b1;
    drain();

    bus.out_ready = 1'b0;
    send(8'h08, 6);
    send(8'h18, 13);
    send(8'h70, 15);
    check("flush_stalled", int'(bus.out_valid), 1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_out_data", int'(bus.out_data), 0);
    check("flush_in_ready", int'(bus.in_ready), 1);
    check("flush_lut_address", int'(lut_address), 0);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    check("flush_no_valid", int'(bus.out_valid), 0);
    lat_chk = 1;
    send(8'hF8, -6);
    drain();
    lat_chk = 0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/act_lut_interp.md
ACT_LUT_INTERP -- requirements
Module: act_lut_interp

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 8: width of signed input, LUT entries and output.
REQ-002 The block SHALL have a parameter ADDR_W, default 4: LUT address width, taken from the upper bits of the input.
REQ-003 The block SHALL have a parameter FRAC_W, default DATA_W-ADDR_W (4): fraction width, taken from the lower bits of the input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: input sample present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: signed sample x, split as {index, frac}.
REQ-009 The block SHALL have port lut_address, output, ADDR_W bits: address driven to the combinational activation LUT.
REQ-010 The block SHALL have port lut_base, input, DATA_W signed bits: LUT value at lut_address.
REQ-011 The block SHALL have port lut_next, input, DATA_W signed bits: LUT successor value; the LUT owns the wrap (15->0) and saturation (7->7) rules.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port out_data, output, DATA_W signed bits: interpolated activation y.

Function
REQ-015 Pipeline SHALL be 3 stages: S1 registers index/frac; S2 registers lut_base, diff=lut_next-lut_base (DATA_W+1 bits signed), and frac; S3 registers y.
REQ-016 lut_address SHALL be driven directly from the S1 index register, with no combinational path from in_data.
REQ-017 Arithmetic: prod = diff * zero-extended frac (DATA_W+FRAC_W+1 bits signed); y = base + (prod >>> FRAC_W), floor rounding, saturated to the signed DATA_W range.
REQ-018 Global advance SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-019 When adv=1, every stage SHALL shift forward one position together with its valid bit; when adv=0, all stage registers SHALL hold.
REQ-020 A sample SHALL be accepted when in_valid && in_ready; out_valid SHALL rise exactly 3 cycles after acceptance when out_ready is held high.
REQ-021 Throughput SHALL be 1 sample per cycle with no bubbles while out_ready=1.
REQ-022 While out_valid=1 && out_ready=0, out_data SHALL remain stable and no sample SHALL be lost or duplicated.
REQ-023 Bubbles (in_valid=0) SHALL propagate as invalid stages; the data of invalid stages is don't-care, but out_data SHALL change only when out_valid is asserted.
REQ-024 Simultaneous output handshake and input acceptance in one cycle SHALL be legal and lossless.

Reset
REQ-025 While rst=1 at a clock edge, all stage valid bits, out_valid, out_data, and lut_address SHALL be cleared to 0.
REQ-026 Asserting rst mid-stream SHALL discard all in-flight samples; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-027 DATA_W, ADDR_W and FRAC_W defaults and a signed saturate function SHALL live in shared package act_pkg.
REQ-028 The S3 multiply-add-saturate datapath SHALL be the single sub-module act_lerp_mac; it is purely combinational, and its output is registered in act_lut_interp.
REQ-029 No other sub-modules SHALL be used; the LUT SHALL remain external.

Verification (LUT = 0,12,15,15,15,15,15,15,-15,-15,-15,-15,-15,-15,-15,-12)
REQ-030 Drive x=0x08, 0x18, 0x70 back to back with out_ready=1 -> y=6, 13, 15 on 3 consecutive cycles, the first 3 cycles after acceptance.
REQ-031 Drive x=0x7F (top-segment saturation) -> y=15; drive x=0x88 -> y=-15.
REQ-032 Drive x=0xF8 (wrap 15->0) -> y=-6; drive x=0xF0 -> y=-12.
REQ-033 Stream 10 samples with out_ready toggled randomly -> all 10 results arrive in order, unchanged while stalled, and in_ready=0 exactly when out_valid=1 && out_ready=0.
REQ-034 Assert rst with 3 samples in flight -> no out_valid afterwards, out_data=0, and the next accepted sample emerges with correct latency 3.
